// File: rtl/decoding_10_8_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decoding_10_8_if : symbol input / decoded output bundle of the 8b/10b decoder
// Rev 1.0
// ---------------------------------------------------------------------------
interface decoding_10_8_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 enable;
  logic [9:0]           Data_10;
  logic                 err_cnt_clr;
  logic [7:0]           data;
  logic                 RXDataK;
  logic                 RXValid;
  logic [2:0]           RXStatus;
  logic                 comma_det;
  logic                 rd_out;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output enable, Data_10, err_cnt_clr,
    input  data, RXDataK, RXValid, RXStatus, comma_det, rd_out, err_cnt
  );

  modport slave (
    input  enable, Data_10, err_cnt_clr,
    output data, RXDataK, RXValid, RXStatus, comma_det, rd_out, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/decoding_10_8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decoding_10_8 : RX 8b/10b decoder with running-disparity tracking and status
// Rev 1.0
// ---------------------------------------------------------------------------
module decoding_10_8 #(
  parameter int   ERR_CNT_W = 8,
  parameter logic RD_INIT   = 1'b0
) (
  input  logic           Bit_Rate_10,
  input  logic           Rst,
  decoding_10_8_if.slave rx
);

  typedef enum logic {RD_NEG = 1'b0, RD_POS = 1'b1} rd_e;

  localparam logic [5:0] C_6B_K28_N = 6'b001111;
  localparam logic [5:0] C_6B_K28_P = 6'b110000;
  localparam logic [5:0] C_6B_D7_N  = 6'b111000;
  localparam logic [5:0] C_6B_D7_P  = 6'b000111;
  localparam logic [3:0] C_4B_D3_N  = 4'b1100;
  localparam logic [3:0] C_4B_D3_P  = 4'b0011;
  localparam logic [3:0] C_4B_A7_N  = 4'b0111;
  localparam logic [3:0] C_4B_A7_P  = 4'b1000;
  localparam logic [3:0] C_4B_P7_N  = 4'b1110;
  localparam logic [3:0] C_4B_P7_P  = 4'b0001;
  localparam logic [7:0] C_EDB      = 8'hFE;

  function automatic logic [2:0] ones6_f(input logic [5:0] v);
    ones6_f = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]) + 3'(v[4]) + 3'(v[5]);
  endfunction

  function automatic logic [2:0] ones4_f(input logic [3:0] v);
    ones4_f = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  // Returns {valid, EDCBA}; both RD columns map to the same value.
  function automatic logic [5:0] dec6_f(input logic [5:0] c);
    case (c)
      6'b100111, 6'b011000: dec6_f = {1'b1, 5'd0};
      6'b011101, 6'b100010: dec6_f = {1'b1, 5'd1};
      6'b101101, 6'b010010: dec6_f = {1'b1, 5'd2};
      6'b110001:            dec6_f = {1'b1, 5'd3};
      6'b110101, 6'b001010: dec6_f = {1'b1, 5'd4};
      6'b101001:            dec6_f = {1'b1, 5'd5};
      6'b011001:            dec6_f = {1'b1, 5'd6};
      6'b111000, 6'b000111: dec6_f = {1'b1, 5'd7};
      6'b111001, 6'b000110: dec6_f = {1'b1, 5'd8};
      6'b100101:            dec6_f = {1'b1, 5'd9};
      6'b010101:            dec6_f = {1'b1, 5'd10};
      6'b110100:            dec6_f = {1'b1, 5'd11};
      6'b001101:            dec6_f = {1'b1, 5'd12};
      6'b101100:            dec6_f = {1'b1, 5'd13};
      6'b011100:            dec6_f = {1'b1, 5'd14};
      6'b010111, 6'b101000: dec6_f = {1'b1, 5'd15};
      6'b011011, 6'b100100: dec6_f = {1'b1, 5'd16};
      6'b100011:            dec6_f = {1'b1, 5'd17};
      6'b010011:            dec6_f = {1'b1, 5'd18};
      6'b110010:            dec6_f = {1'b1, 5'd19};
      6'b001011:            dec6_f = {1'b1, 5'd20};
      6'b101010:            dec6_f = {1'b1, 5'd21};
      6'b011010:            dec6_f = {1'b1, 5'd22};
      6'b111010, 6'b000101: dec6_f = {1'b1, 5'd23};
      6'b110011, 6'b001100: dec6_f = {1'b1, 5'd24};
      6'b100110:            dec6_f = {1'b1, 5'd25};
      6'b010110:            dec6_f = {1'b1, 5'd26};
      6'b110110, 6'b001001: dec6_f = {1'b1, 5'd27};
      6'b001110, 6'b001111,
      6'b110000:            dec6_f = {1'b1, 5'd28};
      6'b101110, 6'b010001: dec6_f = {1'b1, 5'd29};
      6'b011110, 6'b100001: dec6_f = {1'b1, 5'd30};
      6'b101011, 6'b010100: dec6_f = {1'b1, 5'd31};
      default:              dec6_f = 6'd0;
    endcase
  endfunction

  function automatic logic [2:0] dec4_f(input logic [3:0] c);
    case (c)
      4'b1011, 4'b0100:                   dec4_f = 3'd0;
      4'b1001:                            dec4_f = 3'd1;
      4'b0101:                            dec4_f = 3'd2;
      4'b1100, 4'b0011:                   dec4_f = 3'd3;
      4'b1101, 4'b0010:                   dec4_f = 3'd4;
      4'b1010:                            dec4_f = 3'd5;
      4'b0110:                            dec4_f = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: dec4_f = 3'd7;
      default:                            dec4_f = 3'd0;
    endcase
  endfunction

  logic [5:0]           w_six;
  logic [3:0]           w_four;
  logic [2:0]           w_ones6;
  logic [2:0]           w_ones4;
  logic                 w_d6_pos, w_d6_neg, w_d4_pos, w_d4_neg;
  logic [5:0]           w_dec6;
  logic                 w_k28;
  logic [2:0]           w_hgf;
  logic                 w_a7n_ctx, w_a7p_ctx, w_kx7_p6, w_kx7_n6;
  logic                 w_pair_ok, w_x7_ok;
  logic                 w_dec_err, w_disp_err, w_is_k, w_comma;
  logic                 w_rd_mid, w_rd_end;

  logic [7:0]           data_q, data_d;
  logic                 datak_q, datak_d;
  logic                 valid_q;
  logic [2:0]           status_q, status_d;
  logic                 comma_q, comma_d;
  rd_e                  rd_q, rd_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;

  assign w_six    = rx.Data_10[9:4];
  assign w_four   = rx.Data_10[3:0];
  assign w_ones6  = ones6_f(w_six);
  assign w_ones4  = ones4_f(w_four);
  assign w_d6_pos = (w_ones6 == 3'd4);
  assign w_d6_neg = (w_ones6 == 3'd2);
  assign w_d4_pos = (w_ones4 == 3'd3);
  assign w_d4_neg = (w_ones4 == 3'd1);
  assign w_dec6   = dec6_f(w_six);
  assign w_k28    = (w_six == C_6B_K28_N) || (w_six == C_6B_K28_P);

  // K28 RD+ is the bitwise complement of K28 RD-, so the 4b half decodes inverted.
  assign w_hgf = dec4_f((w_six == C_6B_K28_P) ? ~w_four : w_four);

  // 6b contexts that select the alternate x.7 (A7) code instead of primary P7.
  assign w_a7n_ctx = (w_six == 6'b100011) || (w_six == 6'b010011) || (w_six == 6'b001011);
  assign w_a7p_ctx = (w_six == 6'b110100) || (w_six == 6'b101100) || (w_six == 6'b011100);
  assign w_kx7_p6  = (w_six == 6'b111010) || (w_six == 6'b110110) ||
                     (w_six == 6'b101110) || (w_six == 6'b011110);
  assign w_kx7_n6  = (w_six == 6'b000101) || (w_six == 6'b001001) ||
                     (w_six == 6'b010001) || (w_six == 6'b100001);

  // The 4b half must come from the RD column the 6b half leaves behind.
  assign w_pair_ok = !((w_d6_pos || (w_six == C_6B_D7_P)) && (w_d4_pos || (w_four == C_4B_D3_N))) &&
                     !((w_d6_neg || (w_six == C_6B_D7_N)) && (w_d4_neg || (w_four == C_4B_D3_P)));

  always_comb begin
    w_x7_ok = 1'b1;
    case (w_four)
      C_4B_A7_N: w_x7_ok = w_a7n_ctx || w_kx7_n6 || (w_six == C_6B_K28_P);
      C_4B_A7_P: w_x7_ok = w_a7p_ctx || w_kx7_p6 || (w_six == C_6B_K28_N);
      C_4B_P7_N: w_x7_ok = !w_a7n_ctx && (w_six != C_6B_K28_P);
      C_4B_P7_P: w_x7_ok = !w_a7p_ctx && (w_six != C_6B_K28_N);
      default:   w_x7_ok = 1'b1;
    endcase
  end

  assign w_dec_err = !w_dec6[5] || (w_ones4 == 3'd0) || (w_ones4 == 3'd4) ||
                     !w_pair_ok || !w_x7_ok;

  assign w_is_k = w_k28 || ((w_four == C_4B_A7_P) && w_kx7_p6) ||
                  ((w_four == C_4B_A7_N) && w_kx7_n6);

  assign w_comma = w_k28 && !w_dec_err &&
                   ((w_hgf == 3'd1) || (w_hgf == 3'd5) || (w_hgf == 3'd7));

  // On a decode error only the unbalanced sub-blocks move RD.
  always_comb begin
    w_rd_mid = rd_q;
    if (w_d6_pos)
      w_rd_mid = 1'b1;
    else if (w_d6_neg)
      w_rd_mid = 1'b0;
    else if (!w_dec_err && (w_six == C_6B_D7_P))
      w_rd_mid = 1'b1;
    else if (!w_dec_err && (w_six == C_6B_D7_N))
      w_rd_mid = 1'b0;

    w_rd_end = w_rd_mid;
    if (w_d4_pos)
      w_rd_end = 1'b1;
    else if (w_d4_neg)
      w_rd_end = 1'b0;
    else if (!w_dec_err && (w_four == C_4B_D3_P))
      w_rd_end = 1'b1;
    else if (!w_dec_err && (w_four == C_4B_D3_N))
      w_rd_end = 1'b0;
  end

  assign w_disp_err =
      ((rd_q == RD_POS) ? (w_d6_pos || (w_six == C_6B_D7_N))  : (w_d6_neg || (w_six == C_6B_D7_P))) ||
      (w_rd_mid         ? (w_d4_pos || (w_four == C_4B_D3_N)) : (w_d4_neg || (w_four == C_4B_D3_P)));

  always_comb begin
    data_d   = w_dec_err ? C_EDB : {w_hgf, w_dec6[4:0]};
    datak_d  = w_dec_err ? 1'b1 : w_is_k;
    status_d = w_dec_err ? 3'b100 : (w_disp_err ? 3'b111 : 3'b000);
    comma_d  = w_comma;
    rd_d     = rd_e'(w_rd_end);
    err_d    = err_q;
    if (rx.err_cnt_clr)
      err_d = '0;
    else if (rx.enable && (w_dec_err || w_disp_err) && (err_q != {ERR_CNT_W{1'b1}}))
      err_d = err_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge Bit_Rate_10 or posedge Rst) begin
    if (Rst) begin
      data_q   <= 8'h00;
      datak_q  <= 1'b0;
      valid_q  <= 1'b0;
      status_q <= 3'b000;
      comma_q  <= 1'b0;
      rd_q     <= rd_e'(RD_INIT);
      err_q    <= '0;
    end else begin
      err_q   <= err_d;
      valid_q <= rx.enable;
      if (rx.enable) begin
        data_q   <= data_d;
        datak_q  <= datak_d;
        status_q <= status_d;
        comma_q  <= comma_d;
        rd_q     <= rd_d;
      end else begin
        status_q <= 3'b000;
        comma_q  <= 1'b0;
      end
    end
  end

  assign rx.data      = data_q;
  assign rx.RXDataK   = datak_q;
  assign rx.RXValid   = valid_q;
  assign rx.RXStatus  = status_q;
  assign rx.comma_det = comma_q;
  assign rx.rd_out    = rd_q;
  assign rx.err_cnt   = err_q;

endmodule
`default_nettype wire
